// File: rtl/frame_rx_parser.sv
// frame_rx_parser: hub-port receiver that filters frames by destination MAC and buffers payload in a commit/rollback FIFO.
// Define FRAME_RX_PARSER_STATS_EN to build the receive statistics counters; otherwise they read as constant 0.
module frame_rx_parser #(
  parameter logic [47:0] STATION_MAC = 48'h001122334455,
  parameter int MAX_PAYLOAD = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             promisc,
  output logic             frame_valid,
  output logic [47:0]      frame_dest_mac,
  output logic [47:0]      frame_src_mac,
  output logic [7:0]       frame_len,
  output logic             frame_bcast,
  output logic [7:0]       pl_data,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic [CNT_W-1:0] rx_frames_ok,
  output logic [CNT_W-1:0] rx_frames_drop,
  output logic [CNT_W-1:0] rx_runt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, DST, SRC, PAYLOAD, DISCARD} state_t;
  state_t state_q, state_d;
  logic [2:0] hcnt_q, hcnt_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic acc_q, acc_d;
  logic [7:0] len_q, len_d;
  logic [AW:0] wr_q, wr_d, rd_q, cm_q;
  logic [7:0] mem [FIFO_DEPTH];
  logic full, we, commit, runt, drop, pop;
  // The extra pointer bit distinguishes full from empty; uncommitted bytes count as occupied.
  assign full = (wr_q - rd_q) == (AW+1)'(FIFO_DEPTH);
  assign pl_valid = rd_q != cm_q;
  assign pl_data = pl_valid ? mem[rd_q[AW-1:0]] : 8'h00;
  assign pop = pl_valid & pl_ready;
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    dst_d = dst_q;
    src_d = src_q;
    acc_d = acc_q;
    len_d = len_q;
    wr_d = wr_q;
    we = 1'b0;
    commit = 1'b0;
    runt = 1'b0;
    drop = 1'b0;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        dst_d = {dst_q[39:0], rx_data};
        hcnt_d = 3'd1;
        state_d = DST;
      end
      DST: if (!rx_valid) begin
        runt = 1'b1;
        state_d = IDLE;
      end else begin
        dst_d = {dst_q[39:0], rx_data};
        hcnt_d = (hcnt_q == 3'd5) ? 3'd0 : hcnt_q + 3'd1;
        acc_d = (hcnt_q == 3'd5) ? (dst_d == STATION_MAC) | (&dst_d) | promisc : acc_q;
        state_d = (hcnt_q == 3'd5) ? SRC : DST;
      end
      SRC: if (!rx_valid) begin
        runt = 1'b1;
        state_d = IDLE;
      end else begin
        src_d = {src_q[39:0], rx_data};
        hcnt_d = (hcnt_q == 3'd5) ? 3'd0 : hcnt_q + 3'd1;
        len_d = 8'd0;
        state_d = (hcnt_q == 3'd5) ? PAYLOAD : SRC;
      end
      PAYLOAD: if (!rx_valid) begin
        runt = len_q == 8'd0;
        commit = len_q != 8'd0;
        state_d = IDLE;
      end else if (!acc_q) begin
        state_d = DISCARD;
      end else if (len_q == MAX_PAYLOAD[7:0] || full) begin
        wr_d = cm_q;
        state_d = DISCARD;
      end else begin
        we = 1'b1;
        wr_d = wr_q + 1'b1;
        len_d = len_q + 8'd1;
      end
      DISCARD: if (!rx_valid) begin
        drop = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      acc_q <= 1'b0;
      len_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cm_q <= '0;
      frame_valid <= 1'b0;
      frame_dest_mac <= '0;
      frame_src_mac <= '0;
      frame_len <= '0;
      frame_bcast <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      dst_q <= dst_d;
      src_q <= src_d;
      acc_q <= acc_d;
      len_q <= len_d;
      wr_q <= wr_d;
      rd_q <= rd_q + (AW+1)'(pop);
      frame_valid <= commit;
      if (commit) begin
        cm_q <= wr_q;
        frame_dest_mac <= dst_q;
        frame_src_mac <= src_q;
        frame_len <= len_q;
        frame_bcast <= &dst_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wr_q[AW-1:0]] <= rx_data;
  end
`ifdef FRAME_RX_PARSER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_frames_ok <= '0;
      rx_frames_drop <= '0;
      rx_runt <= '0;
    end else begin
      if (commit && !(&rx_frames_ok)) rx_frames_ok <= rx_frames_ok + 1'b1;
      if (drop && !(&rx_frames_drop)) rx_frames_drop <= rx_frames_drop + 1'b1;
      if (runt && !(&rx_runt)) rx_runt <= rx_runt + 1'b1;
    end
  end
`else
  assign rx_frames_ok = '0;
  assign rx_frames_drop = '0;
  assign rx_runt = '0;
`endif
endmodule
